// File: rtl/rvcpu_halt_ctrl.sv
// Tohost responder and halt sequencer: acknowledges CPU bus requests, detects halt
// triggers, stalls and drains the core, then holds a sticky halted state with exit code.
module rvcpu_halt_ctrl #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_valid,
    input  logic             bus_we,
    input  logic [31:0]      bus_addr,
    input  logic [31:0]      bus_wdata,
    input  logic [3:0]       bus_wstrb,
    input  logic             bus_sel,
    output logic             bus_ready,
    output logic             bus_rvalid,
    output logic [31:0]      bus_rdata,
    input  logic             halt_req,
    input  logic [31:0]      halt_a0,
    output logic             cpu_stall,
    output logic             halted,
    output logic [31:0]      exit_code,
    output logic             pass,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DRAIN_W = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_d;
    logic [31:0]        tohost_q;
    logic [31:0]        tohost_d;
    logic [31:0]        exit_d;
    logic [31:0]        rdata_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept;
    logic               addr_hit;
    logic               tohost_wr;
    logic               tohost_trig;
    logic               trig;
    logic [31:0]        trig_code;

    // The bus is never back-pressured, whatever the sequencer is doing.
    assign bus_ready = bus_valid & bus_sel;

    // Next-state, bus decode and trigger arbitration.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        tohost_d    = tohost_q;
        exit_d      = exit_code;
        rdata_d     = bus_rdata;
        cnt_d       = cycle_count;
        accept      = bus_valid & bus_sel;
        addr_hit    = (bus_addr == TOHOST_ADDR);
        tohost_wr   = accept & bus_we & addr_hit & (bus_wstrb == 4'hF) & (state_q == RUN);
        tohost_trig = tohost_wr & bus_wdata[0];
        trig        = tohost_trig | (halt_req & (state_q == RUN));
        // A tohost trigger beats a simultaneous core halt request.
        trig_code   = tohost_trig ? {1'b0, bus_wdata[31:1]} : halt_a0;

        if (accept && !bus_we) begin
            rdata_d = addr_hit ? tohost_q : 32'h0;
        end
        if (tohost_wr) begin
            tohost_d = bus_wdata;
        end

        case (state_q)
            RUN: begin
                if (cycle_count != {CNT_W{1'b1}}) begin
                    cnt_d = cycle_count + CNT_W'(1);
                end
                if (trig) begin
                    exit_d  = trig_code;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            tohost_q    <= '0;
            exit_code   <= '0;
            bus_rdata   <= '0;
            cycle_count <= '0;
            bus_rvalid  <= 1'b0;
            cpu_stall   <= 1'b0;
            halted      <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            tohost_q    <= tohost_d;
            exit_code   <= exit_d;
            bus_rdata   <= rdata_d;
            cycle_count <= cnt_d;
            bus_rvalid  <= accept;
            cpu_stall   <= (state_d != RUN);
            halted      <= (state_d == HALTED);
            pass        <= (state_d == HALTED) && (exit_d == 32'h0);
        end
    end

endmodule

// File: tb/tb_rvcpu_halt_ctrl.sv
// Bench for rvcpu_halt_ctrl: scenario tasks with inline checks, plus a response
// scoreboard that pairs each bus_rvalid pulse with the request that caused it.
module tb_rvcpu_halt_ctrl;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] OTHER  = 32'h0000_2000;

    logic        clk;
    logic        rst_n;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_sel;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        halt_req;
    logic [31:0] halt_a0;
    logic        cpu_stall;
    logic        halted;
    logic [31:0] exit_code;
    logic        pass;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    rvcpu_halt_ctrl #(
        .TOHOST_ADDR (TOHOST),
        .DRAIN_CYCLES(4),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_sel    (bus_sel),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .halt_req   (halt_req),
        .halt_a0    (halt_a0),
        .cpu_stall  (cpu_stall),
        .halted     (halted),
        .exit_code  (exit_code),
        .pass       (pass),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each response pulse retires the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: got rvalid=1, required no response pending");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read && bus_rdata !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL rdata: got %h required %h", bus_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic bus_idle();
        bus_valid = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
    endtask

    task automatic drive_bus(input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [31:0] exp_rdata);
        exp_t e;
        bus_valid = 1'b1;
        bus_sel   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_wstrb = wstrb;
        e.is_read = !we;
        e.data    = exp_rdata;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        halt_req = 1'b0;
        halt_a0  = '0;
        bus_idle();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus_rvalid, cpu_stall, halted, pass} !== 4'b0 || exit_code !== 32'h0
            || bus_rdata !== 32'h0 || cycle_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rv=%b st=%b h=%b p=%b ec=%h rd=%h cc=%0d required all 0",
                     bus_rvalid, cpu_stall, halted, pass, exit_code, bus_rdata, cycle_count);
        end
        repeat (10) step();
        n_checks++;
        if (cycle_count !== 32'd10 || {bus_rvalid, cpu_stall, halted, pass} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_10: got cc=%0d flags=%b required cc=10 flags=0000",
                     cycle_count, {bus_rvalid, cpu_stall, halted, pass});
        end
        bus_valid = 1'b1;
        #1;
        n_checks++;
        if (bus_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_nosel: got %b required 0", bus_ready);
        end
        bus_sel = 1'b1;
        #1;
        n_checks++;
        if (bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_sel: got %b required 1", bus_ready);
        end
        bus_idle();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cycle_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got cc=%0d required 0", cycle_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_halt_pass();
        apply_reset();
        repeat (3) step();
        drive_bus(1'b1, TOHOST, 32'h1, 4'hF, 32'h0);
        step();
        bus_idle();
        n_checks++;
        if (bus_rvalid !== 1'b1 || cpu_stall !== 1'b1 || halted !== 1'b0 || cycle_count !== 32'd4) begin
            n_fail++;
            $display("FAIL trig_edge: got rv=%b st=%b h=%b cc=%0d required rv=1 st=1 h=0 cc=4",
                     bus_rvalid, cpu_stall, halted, cycle_count);
        end
        for (int k = 1; k <= 4; k++) begin
            // A halt request during drain must not overwrite the latched code.
            halt_req = (k == 2);
            halt_a0  = 32'h9;
            step();
            halt_req = 1'b0;
            n_checks++;
            if (halted !== 1'b0 || cpu_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_edge%0d: got h=%b st=%b required h=0 st=1", k, halted, cpu_stall);
            end
        end
        step();
        n_checks++;
        if (halted !== 1'b1 || exit_code !== 32'h0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_pass: got h=%b ec=%h p=%b required h=1 ec=0 p=1", halted, exit_code, pass);
        end
        repeat (3) step();
        n_checks++;
        if (cycle_count !== 32'd4 || halted !== 1'b1 || cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL frozen: got cc=%0d h=%b st=%b required cc=4 h=1 st=1", cycle_count, halted, cpu_stall);
        end
    endtask

    task automatic test_halt_fail();
        apply_reset();
        drive_bus(1'b1, TOHOST, 32'h7, 4'hF, 32'h0);
        step();
        bus_idle();
        repeat (5) step();
        n_checks++;
        if (halted !== 1'b1 || exit_code !== 32'd3 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_fail: got h=%b ec=%h p=%b required h=1 ec=3 p=0", halted, exit_code, pass);
        end
        drive_bus(1'b1, TOHOST, 32'h1, 4'hF, 32'h0);
        step();
        bus_idle();
        repeat (2) step();
        n_checks++;
        if (exit_code !== 32'd3 || pass !== 1'b0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halted_write: got ec=%h p=%b h=%b required ec=3 p=0 h=1", exit_code, pass, halted);
        end
        drive_bus(1'b0, TOHOST, 32'h0, 4'hF, 32'h7);
        step();
        bus_idle();
        n_checks++;
        if (bus_rdata !== 32'h7) begin
            n_fail++;
            $display("FAIL halted_read: got %h required 00000007", bus_rdata);
        end
        step();
    endtask

    task automatic test_partial();
        apply_reset();
        drive_bus(1'b1, TOHOST, 32'h2, 4'hF, 32'h0);
        step();
        drive_bus(1'b1, TOHOST, 32'h1, 4'h1, 32'h0);
        step();
        drive_bus(1'b1, OTHER, 32'h1, 4'hF, 32'h0);
        step();
        bus_idle();
        repeat (6) step();
        n_checks++;
        if (halted !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL no_halt: got h=%b st=%b required h=0 st=0", halted, cpu_stall);
        end
        drive_bus(1'b0, TOHOST, 32'h0, 4'hF, 32'h2);
        step();
        n_checks++;
        if (bus_rdata !== 32'h2) begin
            n_fail++;
            $display("FAIL tohost_read: got %h required 00000002", bus_rdata);
        end
        drive_bus(1'b0, OTHER, 32'h0, 4'hF, 32'h0);
        step();
        bus_idle();
        n_checks++;
        if (bus_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL other_read: got %h required 00000000", bus_rdata);
        end
        step();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        halt_req = 1'b1;
        halt_a0  = 32'h5;
        drive_bus(1'b1, TOHOST, 32'h9, 4'hF, 32'h0);
        step();
        halt_req = 1'b0;
        bus_idle();
        repeat (5) step();
        n_checks++;
        if (halted !== 1'b1 || exit_code !== 32'd4 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous: got h=%b ec=%h p=%b required h=1 ec=4 p=0", halted, exit_code, pass);
        end
    endtask

    task automatic test_reset_in_drain();
        bit seen_halt;
        apply_reset();
        halt_req = 1'b1;
        halt_a0  = 32'h0;
        step();
        halt_req = 1'b0;
        n_checks++;
        if (cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL req_stall: got %b required 1", cpu_stall);
        end
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b0 || halted !== 1'b0 || exit_code !== 32'h0) begin
            n_fail++;
            $display("FAIL drain_reset: got st=%b h=%b ec=%h required 0 0 0", cpu_stall, halted, exit_code);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen_halt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (halted) seen_halt = 1'b1;
        end
        n_checks++;
        if (seen_halt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run: got seen_halt=%b st=%b required 0 0", seen_halt, cpu_stall);
        end
        halt_req = 1'b1;
        halt_a0  = 32'h6;
        step();
        halt_req = 1'b0;
        repeat (4) step();
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_early: got h=%b required 0", halted);
        end
        step();
        n_checks++;
        if (halted !== 1'b1 || exit_code !== 32'h6 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig: got h=%b ec=%h p=%b required h=1 ec=6 p=0", halted, exit_code, pass);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        halt_req = 1'b0;
        halt_a0  = '0;
        bus_idle();
        test_reset();
        test_halt_pass();
        test_halt_fail();
        test_partial();
        test_simultaneous();
        test_reset_in_drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL responses_missing: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
